// File: rtl/sysid_pkg.sv
// Shared constants for the sysid register block: word map, CAPS layout and CONTROL bits.
package sysid_pkg;

    localparam logic [3:0] SYSID_ADDR_ID        = 4'd0;
    localparam logic [3:0] SYSID_ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] SYSID_ADDR_CAPS      = 4'd2;
    localparam logic [3:0] SYSID_ADDR_SCRATCH   = 4'd3;
    localparam logic [3:0] SYSID_ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] SYSID_ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] SYSID_ADDR_CONTROL   = 4'd6;
    localparam logic [3:0] SYSID_ADDR_RSVD      = 4'd7;
    localparam logic [3:0] SYSID_ADDR_USER0     = 4'd8;

    localparam int unsigned SYSID_CAPS_VER_LSB   = 24;
    localparam int unsigned SYSID_CAPS_LAT_LSB   = 16;
    localparam int unsigned SYSID_CAPS_NUSER_LSB = 8;
    localparam int unsigned SYSID_CAPS_UPW_LSB   = 0;
    localparam logic [7:0]  SYSID_CAPS_VERSION   = 8'h01;

    localparam int unsigned SYSID_CTRL_CLEAR  = 0;
    localparam int unsigned SYSID_CTRL_FREEZE = 1;

    function automatic logic [31:0] sysid_caps(input int unsigned lat,
                                               input int unsigned nuser,
                                               input int unsigned upw);
        logic [31:0] w_caps;
        w_caps = '0;
        w_caps[SYSID_CAPS_VER_LSB +: 8]   = SYSID_CAPS_VERSION;
        w_caps[SYSID_CAPS_LAT_LSB +: 4]   = lat[3:0];
        w_caps[SYSID_CAPS_NUSER_LSB +: 8] = nuser[7:0];
        w_caps[SYSID_CAPS_UPW_LSB +: 8]   = upw[7:0];
        return w_caps;
    endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Fixed-latency read return pipe: shifts {valid, data} LATENCY stages; output data holds
// the last valid word between pulses.
module sysid_rd_pipe #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_valid,
    output logic [31:0] o_data
);

    logic [LATENCY-1:0] r_valid;
    logic [31:0]        r_data [LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            // Data stages only load behind a valid so the tail keeps the last returned word.
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/nios_system_sysid_regs.sv
// Avalon-MM system-identification slave: constant ID words, scratch, control and an
// uptime counter whose high half is snapshotted on every UPTIME_LO read.
module nios_system_sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYS_ID       = 32'h0000_0001,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter int unsigned NUM_USER     = 4,
    parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_INIT = '0,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned UPTIME_W     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned          HI_W       = UPTIME_W - 32;
    localparam logic [31:0]          CAPS       = sysid_caps(READ_LATENCY, NUM_USER, UPTIME_W);
    localparam logic [UPTIME_W-1:0]  UPTIME_ONE = 1;

    logic [31:0]         r_scratch;
    logic                r_freeze;
    logic [UPTIME_W-1:0] r_uptime;
    logic [HI_W-1:0]     r_snap;

    logic                w_rd_acc;
    logic                w_wr_scratch;
    logic                w_wr_ctrl;
    logic                w_clear;
    logic [31:0]         w_scratch_d;
    logic [31:0]         w_rdata;

    // A write in the same cycle as a read wins; the read is dropped entirely.
    assign w_rd_acc     = read & ~write;
    assign w_wr_scratch = write & (address == SYSID_ADDR_SCRATCH);
    assign w_wr_ctrl    = write & (address == SYSID_ADDR_CONTROL) & byteenable[0];
    assign w_clear      = w_wr_ctrl & writedata[SYSID_CTRL_CLEAR];

    always_comb begin
        w_scratch_d = r_scratch;
        for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
                w_scratch_d[8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            SYSID_ADDR_ID:        w_rdata = SYS_ID;
            SYSID_ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
            SYSID_ADDR_CAPS:      w_rdata = CAPS;
            SYSID_ADDR_SCRATCH:   w_rdata = r_scratch;
            SYSID_ADDR_UPTIME_LO: w_rdata = r_uptime[31:0];
            SYSID_ADDR_UPTIME_HI: w_rdata[HI_W-1:0] = r_snap;
            SYSID_ADDR_CONTROL:   w_rdata[SYSID_CTRL_FREEZE] = r_freeze;
            default: begin
                for (int unsigned k = 0; k < NUM_USER; k++) begin
                    if (address == SYSID_ADDR_USER0 + 4'(k)) begin
                        w_rdata = USER_INIT[32*k +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
            r_freeze  <= 1'b0;
            r_uptime  <= '0;
            r_snap    <= '0;
        end else begin
            if (w_wr_scratch) begin
                r_scratch <= w_scratch_d;
            end
            if (w_wr_ctrl) begin
                r_freeze <= writedata[SYSID_CTRL_FREEZE];
            end
            if (w_clear) begin
                r_uptime <= '0;
            end else if (!r_freeze) begin
                r_uptime <= r_uptime + UPTIME_ONE;
            end
            // High half captured alongside the LO read so a LO/HI pair is coherent.
            if (w_rd_acc && (address == SYSID_ADDR_UPTIME_LO)) begin
                r_snap <= r_uptime[UPTIME_W-1:32];
            end
        end
    end

    sysid_rd_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .i_clk  (clock),
        .i_rst_n(reset_n),
        .i_valid(w_rd_acc),
        .i_data (w_rdata),
        .o_valid(readdatavalid),
        .o_data (readdata)
    );

endmodule

// File: doc/nios_system_sysid_regs.md
# nios_system_sysid_regs

Parametrised Avalon-MM system-identification slave: the successor to the two-word sysid peripheral. It exposes a build ID, a build timestamp, a capability word, user constant words, a read/write scratch register and a free-running uptime counter with an atomic 64-bit snapshot. Reads use a configurable fixed-latency pipeline with `readdatavalid`. It sits on the Nios system interconnect as a control slave beside the other memory-mapped peripherals.

## Interface
- `SYS_ID`, 32'h0000_0001, build identifier returned at word 0
- `TIMESTAMP`, 32'd0, build time (Unix seconds) returned at word 1
- `NUM_USER`, 4, number of user constant words (0..8)
- `USER_INIT`, all zeros, NUM_USER×32-bit packed vector; word k = bits [32k+31:32k]
- `READ_LATENCY`, 1, cycles from accepted read to `readdatavalid` (1..3)
- `UPTIME_W`, 64, uptime counter width (33..64)

- `clock` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `address` in 4: word address
- `read` in 1: read request
- `write` in 1: write request
- `writedata` in 32: write data
- `byteenable` in 4: byte lanes for writes
- `readdata` out 32: read data, valid when `readdatavalid`=1
- `readdatavalid` out 1: one-cycle pulse per accepted read

## Operation
- Register map (word addresses): 0 ID (RO), 1 TIMESTAMP (RO), 2 CAPS (RO), 3 SCRATCH (RW, byte-enabled), 4 UPTIME_LO (RO), 5 UPTIME_HI (RO snapshot), 6 CONTROL (RW), 7 reserved, 8..8+NUM_USER-1 USER[k] (RO), all other addresses read 0.
- CAPS = {8'h01 version, 4'h0, READ_LATENCY[3:0], NUM_USER[7:0], UPTIME_W[7:0]}.
- Writes to RO or unmapped addresses are ignored.
- Uptime counter: +1 every cycle unless CONTROL.freeze=1. It wraps from 2^UPTIME_W-1 to 0. Bits above UPTIME_W read 0.
- Reading UPTIME_LO returns counter[31:0] as of the accept cycle. In the same cycle it latches counter[UPTIME_W-1:32] into the HI snapshot. UPTIME_HI always returns the snapshot, never the live value.
- CONTROL: bit0 `clear` is write-1 self-clearing and reads 0. bit1 `freeze` is RW. Other bits read 0.
- Clear and increment in the same cycle: clear wins, and the counter becomes 0 at the next edge. Clear does not change the snapshot.
- `read` and `write` asserted together: the write is performed, the read is dropped, and no `readdatavalid` is produced.

## Timing
- No `waitrequest`. A read is accepted every cycle it is asserted, giving full throughput.
- Read data is sampled in the accept cycle. `readdatavalid` and `readdata` appear exactly READ_LATENCY cycles later, in request order.
- Writes take effect at the accept edge. A read accepted one cycle after a write returns the new value.
- `readdata` holds its last value when `readdatavalid`=0. Verification checks data only on valid cycles.
- Reset (async assert, sync deassert assumed upstream) values:
  - `readdata`=0 and `readdatavalid`=0.
  - In-flight pipeline reads are discarded.
  - Scratch=0, counter=0, snapshot=0, freeze=0.
- Reset asserted mid-read: no `readdatavalid` is ever produced for that read.

## Structure
- Package `sysid_pkg`:
  - address constants (`SYSID_ADDR_ID` … `SYSID_ADDR_USER0`)
  - CAPS field positions and version constant
  - CONTROL bit indices
- Sub-module `sysid_rd_pipe`: a READ_LATENCY-deep shift of {valid, data[31:0]} with async reset.
- Top-level: address decode, scratch and control registers, uptime counter and snapshot.

## Test plan
- Reset, then read addresses 0, 1, 2 with SYS_ID=32'hCAFE_0002, TIMESTAMP=32'd1700000000, NUM_USER=2, READ_LATENCY=2, UPTIME_W=48:
  - returns 32'hCAFE_0002, 1700000000 and 32'h0102_0230;
  - each `readdatavalid` arrives exactly 2 cycles after its read.
- Write 32'h1234_5678 to SCRATCH, then write 32'hFFFF_FFFF with byteenable=4'b0101, then read back: returns 32'h12FF_56FF. The read in the cycle after the first write returns 32'h1234_5678.
- Back-to-back reads on addresses 8, 9, 15, 7 (USER_INIT words 32'hA, 32'hB): returns A, B, 0, 0 on four consecutive valid cycles.
- Force counter to 2^32-1 via freeze and clear sequencing (or run 2^32 cycles in fast sim), then read LO then HI: the HI snapshot is consistent with LO across the carry. At UPTIME_W=33, the counter wraps to 0 after 2^33-1.
- Write CONTROL=3 (clear plus freeze), then read UPTIME_LO twice 10 cycles apart: both return 0 and CONTROL reads 32'h2. Write CONTROL=0: the counter resumes.
- Assert `read` and `write` together to SCRATCH with data 5: no `readdatavalid` is produced, and SCRATCH reads 5 afterwards. Assert `reset_n`=0 while a read is in flight: no valid pulse, and all outputs are 0.
